enet_nios_counter_sched: RTL

Scheduler that shares one loadable down-counter chain between NUM_REQ timeout requesters. Candidate requesters are the Ethernet TX backoff, the RX watchdog and the Nios soft-timer. The counter chain is built from counter-mode logic cells. This block arbitrates requests round-robin, sequences the chain's sload/ena/sclr controls, paces decrements with a prescaler, and returns a one-cycle done pulse to the granted requester.

---
 rtl/enet_nios_counter_sched_pkg.sv | 18 +
 rtl/enet_nios_counter_sched_rr_pick.sv | 34 +++
 rtl/enet_nios_counter_sched.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/enet_nios_counter_sched_pkg.sv
// Shared definitions for the counter-chain scheduler: FSM state encoding and
// a width helper for counters whose range may collapse to a single value.
package enet_nios_counter_sched_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RUN    = 3'd2,
        FINISH = 3'd3,
        ABORT  = 3'd4
    } sched_state_t;

    // clog2 that never returns 0, so a 1-value counter still gets a real bit.
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/enet_nios_counter_sched_rr_pick.sv
// Combinational round-robin picker: scans upward from the slot after the last
// grant, wrapping, and returns the first requester found as one-hot plus index.
module enet_nios_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_valid
);

    int w_pos;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_pos   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_pos = int'(i_last) + k;
            if (w_pos >= NUM_REQ) begin
                w_pos = w_pos - NUM_REQ;
            end
            if (!o_valid && i_req[IDX_W'(w_pos)]) begin
                o_valid               = 1'b1;
                o_gnt[IDX_W'(w_pos)]  = 1'b1;
                o_idx                 = IDX_W'(w_pos);
            end
        end
    end

endmodule

// File: rtl/enet_nios_counter_sched.sv
// Shares one external loadable down-counter chain between NUM_REQ timeout
// requesters: round-robin grant, load/run/clear sequencing, prescaled decrements.
module enet_nios_counter_sched
    import enet_nios_counter_sched_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int CNT_WIDTH = 16,
    parameter int PRESCALE  = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*CNT_WIDTH-1:0]   req_load,
    input  logic [NUM_REQ-1:0]             req_abort,
    output logic [NUM_REQ-1:0]             gnt,
    output logic [NUM_REQ-1:0]             done,
    output logic                           busy,
    output logic                           cnt_sload,
    output logic [CNT_WIDTH-1:0]           cnt_data,
    output logic                           cnt_ena,
    output logic                           cnt_sclr,
    input  logic [CNT_WIDTH-1:0]           cnt_value
);

    localparam int IW = clog2_min1(NUM_REQ);
    localparam int PW = clog2_min1(PRESCALE);
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

    sched_state_t           r_state;
    logic [NUM_REQ-1:0]     r_gnt;
    logic [IW-1:0]          r_gnt_idx;
    logic [IW-1:0]          r_last;
    logic [NUM_REQ-1:0]     r_done;
    logic                   r_busy;
    logic                   r_sload;
    logic [CNT_WIDTH-1:0]   r_cnt_data;
    logic                   r_ena;
    logic                   r_sclr;
    logic [PW-1:0]          r_presc;
    logic                   r_abort_pend;

    logic [NUM_REQ-1:0]     w_pick_gnt;
    logic [IW-1:0]          w_pick_idx;
    logic                   w_pick_valid;
    logic [CNT_WIDTH-1:0]   w_pick_load;
    logic [PW-1:0]          w_presc_next;
    logic [CNT_WIDTH-1:0]   w_value_next;
    logic                   w_abort_hit;

    enet_nios_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IW)
    ) u_pick (
        .i_req   (req),
        .i_last  (r_last),
        .o_gnt   (w_pick_gnt),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    always_comb begin
        w_pick_load = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_pick_gnt[k]) begin
                w_pick_load = req_load[k*CNT_WIDTH +: CNT_WIDTH];
            end
        end
    end

    // cnt_ena is registered, so decide it from the value the chain will hold
    // next cycle; this keeps the chain from ever decrementing out of zero.
    assign w_presc_next = (r_presc == PRESC_MAX) ? '0 : r_presc + 1'b1;
    assign w_value_next = cnt_value - CNT_WIDTH'(r_ena);
    assign w_abort_hit  = |(req_abort & r_gnt);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_gnt        <= '0;
            r_gnt_idx    <= '0;
            r_last       <= IW'(NUM_REQ - 1);
            r_done       <= '0;
            r_busy       <= 1'b0;
            r_sload      <= 1'b0;
            r_cnt_data   <= '0;
            r_ena        <= 1'b0;
            r_sclr       <= 1'b1;
            r_presc      <= '0;
            r_abort_pend <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_sclr  <= 1'b0;
                    r_sload <= 1'b0;
                    r_ena   <= 1'b0;
                    r_done  <= '0;
                    if (w_pick_valid) begin
                        r_state      <= LOAD;
                        r_gnt        <= w_pick_gnt;
                        r_gnt_idx    <= w_pick_idx;
                        r_cnt_data   <= w_pick_load;
                        r_sload      <= 1'b1;
                        r_busy       <= 1'b1;
                        r_abort_pend <= 1'b0;
                    end
                end
                // An abort seen while loading is remembered for the first RUN cycle.
                LOAD: begin
                    r_state      <= RUN;
                    r_sload      <= 1'b0;
                    r_presc      <= '0;
                    r_ena        <= (PRESCALE == 1) && (r_cnt_data != '0);
                    r_abort_pend <= w_abort_hit;
                end
                RUN: begin
                    if (r_abort_pend || w_abort_hit) begin
                        r_state <= ABORT;
                        r_ena   <= 1'b0;
                        r_sclr  <= 1'b1;
                    end else if (cnt_value == '0) begin
                        r_state <= FINISH;
                        r_ena   <= 1'b0;
                        r_sclr  <= 1'b1;
                        r_done  <= r_gnt;
                    end else begin
                        r_presc <= w_presc_next;
                        r_ena   <= (w_presc_next == PRESC_MAX) && (w_value_next != '0);
                    end
                end
                FINISH, ABORT: begin
                    r_state      <= IDLE;
                    r_gnt        <= '0;
                    r_done       <= '0;
                    r_busy       <= 1'b0;
                    r_sclr       <= 1'b0;
                    r_last       <= r_gnt_idx;
                    r_abort_pend <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt   <= '0;
                    r_done  <= '0;
                    r_busy  <= 1'b0;
                    r_sload <= 1'b0;
                    r_ena   <= 1'b0;
                    r_sclr  <= 1'b1;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign done      = r_done;
    assign busy      = r_busy;
    assign cnt_sload = r_sload;
    assign cnt_data  = r_cnt_data;
    assign cnt_ena   = r_ena;
    assign cnt_sclr  = r_sclr;

endmodule
